// File: rtl/uart_cmd_sched.sv
// uart_cmd_sched: byte-command parser feeding a response FIFO, plus a
// transmit scheduler that hands bytes to a UART transmitter one at a time.
//
// Commands (parser idle):  'L' <arg> sets leds from arg[2:0] and ACKs,
// '?' returns {5'b0,leds}, 'E' clears err and ACKs, anything else NAKs
// and sets err. A response that finds the FIFO full is dropped and sets err.
//
// Optional feature: define UART_CMD_BEACON_EN to enable the tick/beacon
// path. A tick requests one beacon_data byte, and repeated ticks merge
// while one is pending. The FIFO and the beacon share the transmitter
// round-robin. Without the macro, tick and beacon_data are ignored.
//
// TX handshake: tx_start is a one-cycle registered pulse with tx_data
// valid alongside it; tx_data then holds until the next tx_start. The
// transmitter acknowledges by raising tx_busy and is done when tx_busy
// falls. If tx_busy never rises within 4 cycles the byte counts as sent.

module uart_cmd_sched #(
    parameter int          TXQ_DEPTH = 4,
    parameter logic [7:0]  ACK_BYTE  = 8'h06,
    parameter logic [7:0]  NAK_BYTE  = 8'h15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tick,
    input  logic [7:0] beacon_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [2:0] leds,
    output logic       err
);

    localparam int AW = $clog2(TXQ_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TXQ_DEPTH);

    localparam logic [0:0] P_IDLE = 1'b0;
    localparam logic [0:0] P_ARG  = 1'b1;

    localparam logic [1:0] T_IDLE    = 2'd0;
    localparam logic [1:0] T_START   = 2'd1;
    localparam logic [1:0] T_WAIT_HI = 2'd2;
    localparam logic [1:0] T_WAIT_LO = 2'd3;

    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_Q = 8'h3F;
    localparam logic [7:0] CMD_E = 8'h45;

    logic [0:0]    p_state, p_next;
    logic [1:0]    t_state;
    logic [1:0]    hi_cnt;

    logic          enq;
    logic [7:0]    enq_data;
    logic          err_set, err_clr, leds_we;

    logic [7:0]    mem [TXQ_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty, push_ok, drop, deq;

    logic          src_beacon;
    logic          pick_beacon;
    logic          any_pend;
    logic [7:0]    head_data;

    assign fifo_empty = (count == '0);
    assign deq        = (t_state == T_START) && !src_beacon;
    assign push_ok    = enq && ((count != FULL_CNT) || deq);
    assign drop       = enq && !push_ok;

    // Command decode: decides next parser state and what (if anything) to enqueue.
    always_comb begin
        p_next   = p_state;
        enq      = 1'b0;
        enq_data = 8'h00;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        leds_we  = 1'b0;
        if (rx_valid) begin
            if (p_state == P_IDLE) begin
                case (rx_data)
                    CMD_L: p_next = P_ARG;
                    CMD_Q: begin
                        enq      = 1'b1;
                        enq_data = {5'b0, leds};
                    end
                    CMD_E: begin
                        err_clr  = 1'b1;
                        enq      = 1'b1;
                        enq_data = ACK_BYTE;
                    end
                    default: begin
                        enq      = 1'b1;
                        enq_data = NAK_BYTE;
                        err_set  = 1'b1;
                    end
                endcase
            end else begin
                leds_we  = 1'b1;
                enq      = 1'b1;
                enq_data = ACK_BYTE;
                p_next   = P_IDLE;
            end
        end
    end

    // Parser state, LED register and sticky error (setting wins over clearing).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            p_state <= P_IDLE;
            leds    <= 3'b000;
            err     <= 1'b0;
        end else begin
            p_state <= p_next;
            if (leds_we)
                leds <= rx_data[2:0];
            if (err_set || drop)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= enq_data;
    end

    // FIFO pointers and occupancy; a pop in the same cycle frees room for a full push.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef UART_CMD_BEACON_EN
    logic beacon_pend;
    logic last_beacon;

    assign any_pend    = !fifo_empty || beacon_pend;
    assign pick_beacon = beacon_pend && (fifo_empty || !last_beacon);
    assign head_data   = pick_beacon ? beacon_data : mem[rd_ptr];

    // Beacon request latch; ticks merge while pending, a new tick beats the clear.
    always_ff @(posedge clk) begin
        if (!resetn)
            beacon_pend <= 1'b0;
        else if (tick)
            beacon_pend <= 1'b1;
        else if ((t_state == T_START) && src_beacon)
            beacon_pend <= 1'b0;
    end

    // Remember the last source served; starting as "beacon" gives the FIFO first turn.
    always_ff @(posedge clk) begin
        if (!resetn)
            last_beacon <= 1'b1;
        else if ((t_state == T_IDLE) && !tx_busy && any_pend)
            last_beacon <= pick_beacon;
    end
`else
    logic unused_beacon;

    assign any_pend      = !fifo_empty;
    assign pick_beacon   = 1'b0;
    assign head_data     = mem[rd_ptr];
    assign unused_beacon = ^{tick, beacon_data};
`endif

    // Transmit scheduler: launch one byte, then wait for the transmitter to finish.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            t_state    <= T_IDLE;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            src_beacon <= 1'b0;
            hi_cnt     <= 2'd0;
        end else begin
            tx_start <= 1'b0;
            case (t_state)
                T_IDLE: begin
                    if (!tx_busy && any_pend) begin
                        t_state    <= T_START;
                        tx_start   <= 1'b1;
                        tx_data    <= head_data;
                        src_beacon <= pick_beacon;
                    end
                end
                T_START: begin
                    t_state <= T_WAIT_HI;
                    hi_cnt  <= 2'd0;
                end
                T_WAIT_HI: begin
                    if (tx_busy)
                        t_state <= T_WAIT_LO;
                    else if (hi_cnt == 2'd3)
                        t_state <= T_IDLE;
                    else
                        hi_cnt <= hi_cnt + 2'd1;
                end
                T_WAIT_LO: begin
                    if (!tx_busy)
                        t_state <= T_IDLE;
                end
                default: t_state <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Bench for uart_cmd_sched. Responses are predicted when commands are
// driven and pushed to exp_q; every tx_start pops and compares tx_data.
// A small transmitter model raises tx_busy for 3 cycles after each tx_start;
// busy_hold forces tx_busy high. Beacon scenario follows UART_CMD_BEACON_EN.

module tb_uart_cmd_sched;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tick = 1'b0;
    logic [7:0] beacon_data = 8'h00;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [2:0] leds;
    logic       err;

    logic       busy_hold = 1'b0;
    logic       model_busy = 1'b0;
    int         busy_cnt = 0;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_starts = 0;
    int         last_start_cyc = 0;
    bit         have_prev = 1'b0;
    logic [7:0] mon_exp;
    logic [7:0] exp_q[$];

    assign tx_busy = busy_hold | model_busy;

    uart_cmd_sched dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tick        (tick),
        .beacon_data (beacon_data),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .leds        (leds),
        .err         (err)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, scoreboard check and transmitter model, all on the falling edge
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: tx_start with tx_data=%h, required no tx_start", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tx_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL tx_data: got %h, required %h (cycle %0d)", tx_data, mon_exp, cyc);
                end
            end
            if (have_prev) begin
                n_tests++;
                if (cyc - last_start_cyc < 3) begin
                    n_fail++;
                    $display("FAIL tx_gap: got %0d cycles, required >= 3", cyc - last_start_cyc);
                end
            end
            have_prev      = 1'b1;
            last_start_cyc = cyc;
            n_starts++;
            busy_cnt = 3;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        model_busy = (busy_cnt != 0);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        busy_hold = 1'b0;
        rx_valid  = 1'b0;
        tick      = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d bytes still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_starts(input int target, input string name);
        int k = 0;
        while (n_starts < target && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_tests++;
        if (n_starts < target) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d tx_starts, required %0d", name, n_starts, target);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_tests += 4;
        if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b, required 0", tx_start); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        if (leds !== 3'b000)   begin n_fail++; $display("FAIL reset_leds: got %b, required 000", leds); end
        if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_led_set();
        int s0 = n_starts;
        exp_q.push_back(8'h06);
        send_byte(8'h4C);
        send_byte(8'h05);
        wait_drain("led_set");
        n_tests += 3;
        if (leds !== 3'b101) begin n_fail++; $display("FAIL led_set_leds: got %b, required 101", leds); end
        if (err !== 1'b0)    begin n_fail++; $display("FAIL led_set_err: got %b, required 0", err); end
        if (n_starts - s0 != 1) begin n_fail++; $display("FAIL led_set_count: got %0d tx_starts, required 1", n_starts - s0); end
    endtask

    task automatic test_query_latency();
        int n_cyc;
        int s0 = n_starts;
        exp_q.push_back(8'h05);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h3F;
        n_cyc    = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        wait_starts(s0 + 1, "query");
        n_tests++;
        if (last_start_cyc != n_cyc + 2) begin
            n_fail++;
            $display("FAIL query_latency: got tx_start at N+%0d, required N+2", last_start_cyc - n_cyc);
        end
        wait_drain("query");
    endtask

    task automatic test_nak_err();
        exp_q.push_back(8'h15);
        send_byte(8'h00);
        @(negedge clk);
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL nak_err_set: got %b, required 1", err); end
        wait_drain("nak");
        exp_q.push_back(8'h06);
        send_byte(8'h45);
        @(negedge clk);
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL nak_err_clear: got %b, required 0", err); end
        wait_drain("err_clear");
    endtask

    task automatic test_overflow();
        int s0 = n_starts;
        @(negedge clk);
        busy_hold = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h05);
        for (int i = 0; i < 6; i++) send_byte(8'h3F);
        @(negedge clk);
        n_tests += 2;
        if (err !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b, required 1", err); end
        if (n_starts != s0) begin n_fail++; $display("FAIL overflow_held: got %0d tx_starts while busy, required 0", n_starts - s0); end
        busy_hold = 1'b0;
        wait_drain("overflow");
        n_tests++;
        if (n_starts - s0 != 4) begin n_fail++; $display("FAIL overflow_count: got %0d tx_starts, required 4", n_starts - s0); end
        exp_q.push_back(8'h06);
        send_byte(8'h45);
        wait_drain("overflow_clear");
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL overflow_err_clear: got %b, required 0", err); end
    endtask

    task automatic test_full_push_pop();
        int s0 = n_starts;
        @(negedge clk);
        busy_hold = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h05);
        for (int i = 0; i < 4; i++) send_byte(8'h3F);
        @(negedge clk);
        busy_hold = 1'b0;
        send_byte(8'h3F);
        wait_drain("full_push_pop");
        n_tests += 2;
        if (err !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_err: got %b, required 0", err); end
        if (n_starts - s0 != 5) begin n_fail++; $display("FAIL full_push_pop_count: got %0d tx_starts, required 5", n_starts - s0); end
    endtask

    task automatic test_beacon();
        int s0;
        do_reset();
        s0 = n_starts;
        beacon_data = 8'hA5;
        exp_q.push_back(8'h00);
`ifdef UART_CMD_BEACON_EN
        exp_q.push_back(8'hA5);
`endif
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h3F;
        tick     = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        tick = 1'b0;
        wait_drain("beacon");
        repeat (10) @(negedge clk);
        n_tests++;
`ifdef UART_CMD_BEACON_EN
        if (n_starts - s0 != 2) begin n_fail++; $display("FAIL beacon_count: got %0d tx_starts, required 2", n_starts - s0); end
`else
        if (n_starts - s0 != 1) begin n_fail++; $display("FAIL beacon_ignored: got %0d tx_starts, required 1", n_starts - s0); end
`endif
    endtask

    task automatic test_reset_midtx();
        int s0;
        exp_q.push_back(8'h06);
        send_byte(8'h4C);
        send_byte(8'h03);
        wait_drain("midtx_setup");
        s0 = n_starts;
        exp_q.push_back(8'h03);
        for (int i = 0; i < 3; i++) send_byte(8'h3F);
        wait_starts(s0 + 1, "midtx");
        @(negedge clk);
        @(negedge clk);
        busy_hold = 1'b1;
        resetn    = 1'b0;
        @(negedge clk);
        n_tests += 4;
        if (tx_start !== 1'b0) begin n_fail++; $display("FAIL midtx_tx_start: got %b, required 0", tx_start); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL midtx_tx_data: got %h, required 00", tx_data); end
        if (leds !== 3'b000)   begin n_fail++; $display("FAIL midtx_leds: got %b, required 000", leds); end
        if (err !== 1'b0)      begin n_fail++; $display("FAIL midtx_err: got %b, required 0", err); end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        busy_hold = 1'b0;
        repeat (30) @(negedge clk);
        n_tests++;
        if (n_starts - s0 != 1) begin n_fail++; $display("FAIL midtx_no_resume: got %0d tx_starts, required 1", n_starts - s0); end
    endtask

    initial begin
        test_reset();
        test_led_set();
        test_query_latency();
        test_nak_err();
        test_overflow();
        test_full_push_pop();
        test_beacon();
        test_reset_midtx();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d bytes never sent, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sched.md
UART_CMD_SCHED -- requirements
Module: uart_cmd_sched

Interface
REQ-001 SHALL have parameter TXQ_DEPTH, default 4, response FIFO depth in bytes (power of 2, min 2).
REQ-002 SHALL have parameter ACK_BYTE, default 8'h06, byte returned on accepted command.
REQ-003 SHALL have parameter NAK_BYTE, default 8'h15, byte returned on unknown command.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port resetn  in  1  synchronous, active-low reset.
REQ-006 SHALL have port rx_valid  in  1  one-cycle strobe from UART receiver, byte ready.
REQ-007 SHALL have port rx_data  in  8  received byte, valid with rx_valid.
REQ-008 SHALL have port tick  in  1  beacon request strobe.
REQ-009 SHALL have port beacon_data  in  8  byte to send on beacon; sampled at tx_start.
REQ-010 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-011 SHALL have port tx_start  out  1  one-cycle registered send request.
REQ-012 SHALL have port tx_data  out  8  byte to send; held stable from tx_start until tx_busy falls.
REQ-013 SHALL have port leds  out  3  LED state register.
REQ-014 SHALL have port err  out  1  sticky error flag.

Function
REQ-015 Parser FSM states P_IDLE, P_ARG; leaves P_IDLE only on rx_valid.
REQ-016 In P_IDLE: 8'h4C 'L' -> P_ARG, no response; 8'h3F '?' -> enqueue {5'b0,leds}; 8'h45 'E' -> clear err, enqueue ACK_BYTE; other byte -> enqueue NAK_BYTE, set err.
REQ-017 In P_ARG: on rx_valid, leds <= rx_data[2:0], enqueue ACK_BYTE, -> P_IDLE.
REQ-018 Enqueue with FIFO full SHALL drop the byte and set err; FIFO contents unchanged.
REQ-019 Simultaneous enqueue and dequeue with FIFO full SHALL succeed (no drop).
REQ-020 FIFO pointers TXQ_DEPTH-modulo wrap; count width clog2(TXQ_DEPTH)+1.
REQ-021 tick sets beacon_pend; tick while pending is merged (one beacon).
REQ-022 TX FSM states T_IDLE, T_START, T_WAIT_HI, T_WAIT_LO.
REQ-023 T_IDLE -> T_START when tx_busy=0 and (FIFO non-empty or beacon_pend); tx_data loaded on transition.
REQ-024 Arbitration round-robin: when both pending, source not served last wins; after reset FIFO has priority.
REQ-025 T_START: tx_start=1 for exactly one cycle; beacon source clears beacon_pend, FIFO source pops; -> T_WAIT_HI.
REQ-026 T_WAIT_HI: tx_busy=1 -> T_WAIT_LO; 4 cycles without tx_busy -> T_IDLE (byte treated as sent).
REQ-027 T_WAIT_LO: tx_busy=0 -> T_IDLE.
REQ-028 Latency: rx_valid '?' in cycle N with idle TX and empty FIFO -> tx_start in cycle N+2.
REQ-029 Minimum gap between consecutive tx_start pulses SHALL be 3 cycles.
REQ-030 rx_valid during any TX state SHALL be parsed normally (parser and TX independent).

Reset
REQ-031 resetn=0 at posedge: P_IDLE, T_IDLE, FIFO empty, beacon_pend=0, tx_start=0, tx_data=0, leds=0, err=0.
REQ-032 Reset mid-transmission SHALL abandon the byte; no tx_start until resetn=1 and tx_busy=0.

Configuration
REQ-033 Macro UART_CMD_BEACON_EN defined: tick/beacon path per REQ-021..025.
REQ-034 UART_CMD_BEACON_EN undefined: beacon_pend logic absent, tick and beacon_data ignored, FIFO sole TX source; ports remain.

Verification
REQ-035 Reset, send 'L',8'h05 -> leds=3'b101, one tx_start with tx_data=8'h06.
REQ-036 Send '?' after REQ-035 -> tx_start at N+2, tx_data=8'h05.
REQ-037 Send 8'h00 -> tx_data=8'h15, err=1; then 'E' -> err=0, tx_data=8'h06.
REQ-038 tx_busy held 1, send six '?' -> 4 bytes queued, err=1, 4 tx_starts after tx_busy releases.
REQ-039 BEACON_EN, beacon_data=8'hA5, tick twice plus '?' same cycle, tx idle -> order leds byte, 8'hA5; one beacon only.
REQ-040 Reset asserted in T_WAIT_LO -> all outputs zero next cycle, FIFO empty, no further tx_start.
